hazard_sb: RTL and testbench

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_pkg.sv | 11 +
 rtl/hazard_sb_cnt.sv | 32 +++
 rtl/hazard_sb.sv | 106 ++++++++++
 tb/tb_hazard_sb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizes for the register hazard scoreboard.
package hazard_pkg;
  localparam int NUM_ARCH_REGS = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;
endpackage

// File: rtl/hazard_sb_cnt.sv
// Loadable countdown: flush beats set, set beats decrement, holds at zero.
module hazard_sb_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         set,
  input  logic [W-1:0] set_val,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (set)
      cnt_d = set_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_sb.sv
// Register scoreboard with divider occupancy, stall generation and forwarding select.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int NRP     = 3,
  parameter int LAT_W   = 4,
  parameter int DIV_LAT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 id_issue,
  input  logic [4:0]           id_dest,
  input  logic [LAT_W-1:0]     id_lat,
  input  logic                 id_is_div,
  input  logic [NRP-1:0][4:0]  id_raddr,
  input  logic [NRP-1:0]       id_rvalid,
  input  logic [4:0]           es_dest,
  input  logic [4:0]           ms_dest,
  input  logic [4:0]           ws_dest,
  input  logic                 es_valid,
  input  logic                 ms_valid,
  input  logic                 ws_valid,
  input  logic                 flush,
  output logic                 block_id,
  output logic [NRP-1:0][1:0]  fwd_sel,
  output logic                 div_busy,
  output logic [31:0]          stall_cnt
);
  logic [LAT_W-1:0] sb [NUM_ARCH_REGS];
  logic [LAT_W-1:0] div_cnt;
  logic [NRP-1:0]   port_haz;
  logic             issue_ok;

  // A flush squashes the instruction issuing in the same cycle.
  assign issue_ok = id_issue && !flush;
  assign sb[0]    = '0;

  for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_sb
    hazard_sb_cnt #(.W(LAT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .set     (issue_ok && (id_dest == 5'(r))),
      .set_val (id_lat),
      .cnt     (sb[r])
    );
  end

  hazard_sb_cnt #(.W(LAT_W)) u_div_cnt (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .set     (issue_ok && id_is_div),
    .set_val (LAT_W'(DIV_LAT)),
    .cnt     (div_cnt)
  );

  assign div_busy = (div_cnt != '0);

  always_comb begin
    for (int i = 0; i < NRP; i++)
      port_haz[i] = id_rvalid[i] && (id_raddr[i] != 5'd0) && (sb[id_raddr[i]] != '0);
  end

  assign block_id = !reset && id_valid && ((|port_haz) || (id_is_div && div_busy));

  // Youngest in-flight producer wins, so EXE is checked before MEM and WB.
  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      fwd_sel_e sel;
      sel = FWD_RF;
      if (!reset && id_rvalid[i]) begin
        if (es_valid && es_dest != 5'd0 && es_dest == id_raddr[i])
          sel = FWD_EXE;
        else if (ms_valid && ms_dest != 5'd0 && ms_dest == id_raddr[i])
          sel = FWD_MEM;
        else if (ws_valid && ws_dest != 5'd0 && ws_dest == id_raddr[i])
          sel = FWD_WB;
      end
      fwd_sel[i] = sel;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && block_id && !flush && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed scenarios plus randomized traffic against a scoreboard model.
module tb_hazard_sb;
  localparam int NRP     = 3;
  localparam int LAT_W   = 4;
  localparam int DIV_LAT = 10;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                id_valid, id_issue, id_is_div, flush;
  logic [4:0]          id_dest, es_dest, ms_dest, ws_dest;
  logic [LAT_W-1:0]    id_lat;
  logic [NRP-1:0][4:0] id_raddr;
  logic [NRP-1:0]      id_rvalid;
  logic                es_valid, ms_valid, ws_valid;
  logic                block_id, div_busy;
  logic [NRP-1:0][1:0] fwd_sel;
  logic [31:0]         stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining cycles per register, divider occupancy, stall count.
  int          sb_m [32];
  int          div_m;
  longint      stall_m;

  hazard_sb #(.NRP(NRP), .LAT_W(LAT_W), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_issue(id_issue),
    .id_dest(id_dest), .id_lat(id_lat), .id_is_div(id_is_div),
    .id_raddr(id_raddr), .id_rvalid(id_rvalid),
    .es_dest(es_dest), .ms_dest(ms_dest), .ws_dest(ws_dest),
    .es_valid(es_valid), .ms_valid(ms_valid), .ws_valid(ws_valid),
    .flush(flush), .block_id(block_id), .fwd_sel(fwd_sel),
    .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) sb_m[r] = 0;
    div_m = 0;
  endtask

  function automatic bit exp_block();
    bit haz;
    haz = 1'b0;
    if (reset) return 1'b0;
    for (int i = 0; i < NRP; i++)
      if (id_rvalid[i] && id_raddr[i] != 0 && sb_m[id_raddr[i]] > 0) haz = 1'b1;
    return id_valid && (haz || (id_is_div && div_m > 0));
  endfunction

  function automatic int exp_fwd(input int i);
    if (reset || !id_rvalid[i]) return 0;
    if (es_valid && es_dest != 0 && es_dest == id_raddr[i]) return 1;
    if (ms_valid && ms_dest != 0 && ms_dest == id_raddr[i]) return 2;
    if (ws_valid && ws_dest != 0 && ws_dest == id_raddr[i]) return 3;
    return 0;
  endfunction

  task automatic check_now();
    @(negedge clk);
    chk("block_id", block_id, exp_block());
    chk("div_busy", div_busy, (!reset && div_m > 0));
    for (int i = 0; i < NRP; i++) chk($sformatf("fwd_sel%0d", i), fwd_sel[i], exp_fwd(i));
    chk("stall_cnt", stall_cnt, stall_m);
  endtask

  task automatic tick();
    bit blk;
    blk = exp_block();
    @(posedge clk);
    if (reset) begin
      model_clear();
      stall_m = 0;
    end else begin
      if (PERF && id_valid && blk && !flush && stall_m != 64'hFFFF_FFFF) stall_m++;
      if (flush) model_clear();
      else begin
        for (int r = 1; r < 32; r++)
          if (id_issue && id_dest == r) sb_m[r] = int'(id_lat);
          else if (sb_m[r] > 0) sb_m[r]--;
        if (id_issue && id_is_div) div_m = DIV_LAT;
        else if (div_m > 0) div_m--;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_issue = 0; id_dest = 0; id_lat = 0; id_is_div = 0;
    id_raddr = '0; id_rvalid = '0; flush = 0;
    es_dest = 0; ms_dest = 0; ws_dest = 0; es_valid = 0; ms_valid = 0; ws_valid = 0;
  endtask

  initial begin
    int cnt;
    model_clear();
    stall_m = 0;
    idle_inputs();
    reset = 1'b1;

    // Outputs forced quiet while reset is held, even with matching stages.
    id_valid = 1; id_is_div = 1; id_rvalid = '1; id_raddr[0] = 5'd4;
    es_valid = 1; es_dest = 5'd4;
    check_now();
    chk("rst_block", block_id, 0);
    chk("rst_fwd0", fwd_sel[0], 0);
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    check_now();
    tick();

    // ALU chain: lat 0 producer, consumer forwards from EXE without stall.
    id_valid = 1; id_issue = 1; id_dest = 5'd5; id_lat = 0;
    check_now();
    tick();
    idle_inputs();
    id_valid = 1; id_rvalid[0] = 1; id_raddr[0] = 5'd5; es_valid = 1; es_dest = 5'd5;
    check_now();
    chk("alu_block", block_id, 0);
    chk("alu_fwd", fwd_sel[0], 1);
    tick();

    // Load-use: one stall cycle, then forward from MEM.
    idle_inputs();
    id_valid = 1; id_issue = 1; id_dest = 5'd7; id_lat = 1;
    check_now();
    tick();
    idle_inputs();
    id_valid = 1; id_rvalid[2] = 1; id_raddr[2] = 5'd7; es_valid = 1; es_dest = 5'd7;
    check_now();
    chk("lu_stall", block_id, 1);
    tick();
    es_valid = 0; ms_valid = 1; ms_dest = 5'd7;
    check_now();
    chk("lu_go", block_id, 0);
    chk("lu_fwd", fwd_sel[2], 2);
    tick();

    // Divider: back-to-back divs, second stalls for the full occupancy.
    idle_inputs();
    id_valid = 1; id_issue = 1; id_is_div = 1; id_dest = 5'd3; id_lat = 4'd10;
    check_now();
    tick();
    id_issue = 0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      check_now();
      if (!block_id) break;
      cnt++;
      tick();
    end
    chk("div2_stall", cnt, 10);
    id_issue = 1;
    tick();
    idle_inputs();
    id_valid = 1; id_rvalid[1] = 1; id_raddr[1] = 5'd3;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      check_now();
      if (!block_id) break;
      cnt++;
      tick();
    end
    chk("r3_stall", cnt, 10);
    tick();

    // Flush while sb[r9]=4; a same-cycle issue must leave nothing behind.
    idle_inputs();
    id_valid = 1; id_issue = 1; id_dest = 5'd9; id_lat = 4'd6;
    check_now();
    tick();
    idle_inputs();
    tick();
    tick();
    id_valid = 1; id_rvalid[0] = 1; id_raddr[0] = 5'd9;
    check_now();
    chk("pre_flush_blk", block_id, 1);
    flush = 1; id_issue = 1; id_dest = 5'd10; id_lat = 4'd5; id_is_div = 1;
    tick();
    idle_inputs();
    id_valid = 1; id_is_div = 1; id_rvalid = 3'b011; id_raddr[0] = 5'd9; id_raddr[1] = 5'd10;
    check_now();
    chk("flush_blk", block_id, 0);
    chk("flush_div", div_busy, 0);
    tick();

    // Reset mid-divide: busy must drop with no clock edge.
    idle_inputs();
    id_valid = 1; id_issue = 1; id_is_div = 1; id_dest = 5'd12; id_lat = 4'd2;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
    check_now();
    chk("mid_div_busy", div_busy, 1);
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) if (sb_m[r] > 0) sb_m[r]--;
    if (div_m > 0) div_m--;
    #1;
    reset = 1'b1;
    model_clear();
    stall_m = 0;
    #1;
    chk("async_div_busy", div_busy, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    tick();
    reset = 1'b0;

    // r0 is never a hazard nor a forwarding source.
    idle_inputs();
    id_valid = 1; id_rvalid[0] = 1; id_raddr[0] = 5'd0; ws_valid = 1; ws_dest = 5'd0;
    check_now();
    chk("r0_fwd", fwd_sel[0], 0);
    chk("r0_block", block_id, 0);
    chk("r0_stall", stall_cnt, stall_m);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      id_valid  = ($urandom % 4) != 0;
      id_issue  = $urandom % 2;
      id_dest   = 5'($urandom % 32);
      id_lat    = LAT_W'($urandom % 4);
      id_is_div = ($urandom % 8) == 0;
      for (int i = 0; i < NRP; i++) id_raddr[i] = 5'($urandom % 8);
      id_rvalid = NRP'($urandom);
      es_dest   = 5'($urandom % 8); es_valid = $urandom % 2;
      ms_dest   = 5'($urandom % 8); ms_valid = $urandom % 2;
      ws_dest   = 5'($urandom % 8); ws_valid = $urandom % 2;
      flush     = ($urandom % 20) == 0;
      check_now();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
